// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_pkg
//  Description : Shared op encodings, FSM states and latency for muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Edges from accepted start to HI/LO written: load, WIDTH iterations, fix-up.
    localparam int MD_LATENCY = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request / HI-LO result bundle between EX stage and muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational shift-add (mul) or restoring (div) iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic                 i_is_div,
    input  wire logic [2*WIDTH-1:0]   i_acc,
    input  wire logic [WIDTH:0]       i_rem,
    input  wire logic [WIDTH-1:0]     i_operand,
    output logic      [2*WIDTH-1:0]   o_acc,
    output logic      [WIDTH:0]       o_rem
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;

    // Mul: acc = {partial product, multiplier}. Div: acc[WIDTH-1:0] shifts
    // dividend bits out the top while quotient bits enter at the bottom.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
        w_shift = {i_rem[WIDTH-1:0], i_acc[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, i_operand};
        o_acc   = i_acc;
        o_rem   = i_rem;
        if (i_is_div) begin
            if (!w_diff[WIDTH+1]) begin
                o_rem = w_diff[WIDTH:0];
                o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_rem = w_shift;
                o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], 1'b0};
            end
        end else if (i_acc[0]) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    md_state_t            r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_b_zero;
    logic [WIDTH-1:0]     r_a_orig;
    logic [WIDTH-1:0]     r_operand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH:0]       r_rem;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH:0]       w_rem_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Negating the most-negative value yields itself, which is exactly its
    // unsigned magnitude, so no special case is needed.
    assign w_signed   = ~bus.op[0];
    assign w_a_neg    = w_signed & bus.a[WIDTH-1];
    assign w_b_neg    = w_signed & bus.b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag    = w_b_neg ? -bus.b : bus.b;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_rem     (r_rem),
        .i_operand (r_operand),
        .o_acc     (w_acc_next),
        .o_rem     (w_rem_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_a_orig  <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_is_div  <= bus.op[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_b_zero  <= (bus.b == '0);
                        r_a_orig  <= bus.a;
                        r_operand <= w_b_mag;
                        r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
                        r_rem     <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= CALC;
                    end else begin
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_last) r_state <= FIX;
                end
                FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_b_zero) begin
                        r_hi <= r_a_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end
                    r_dbz   <= r_is_div & r_b_zero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed scoreboard bench for muldiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, ".hi"}, bus.hi, mon_e.hi);
                check({mon_e.name, ".lo"}, bus.lo, mon_e.lo);
                check({mon_e.name, ".dbz"}, {31'b0, bus.div_by_zero}, {31'b0, mon_e.dbz});
            end
        end
        if (bus.div_by_zero === 1'b1 && bus.done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL dbz_without_done: got div_by_zero=1 done=%b, expected done=1", bus.done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while (bus.busy !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
        if (bus.busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.idle_timeout: got busy=%b, expected 0 within 100 cycles", name, bus.busy);
        end
    endtask

    task automatic launch(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b);
        wait_idle(name);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_op(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] ehi, logic [31:0] elo, logic edbz);
        int cnt = 0;
        sb.push_back('{name, ehi, elo, edbz});
        launch(name, op, a, b);
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check({name, ".busy_cycles"}, 32'(cnt), 32'(MD_LATENCY));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;

        repeat (3) tick();
        check("reset.busy", {31'b0, bus.busy}, 32'd0);
        check("reset.done", {31'b0, bus.done}, 32'd0);
        check("reset.dbz",  {31'b0, bus.div_by_zero}, 32'd0);
        check("reset.hi",   bus.hi, 32'd0);
        check("reset.lo",   bus.lo, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_min",  MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("divu_7_2",  MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
        run_op("div_m7_2",  MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_7_m2",  MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_by0",  MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
        run_op("div_by0",   MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        tick();

        // MTHI then MTLO in IDLE
        bus.wdata = 32'h12345678;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        check("mthi.hi", bus.hi, 32'h12345678);
        check("mthi.lo", bus.lo, 32'hFFFFFFFF);
        bus.wdata = 32'h9ABCDEF0;
        bus.mtlo  = 1'b1;
        tick();
        bus.mtlo  = 1'b0;
        check("mtlo.lo", bus.lo, 32'h9ABCDEF0);
        check("mtlo.hi", bus.hi, 32'h12345678);
        bus.wdata = 32'h55AA55AA;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("mthilo.hi", bus.hi, 32'h55AA55AA);
        check("mthilo.lo", bus.lo, 32'h55AA55AA);

        // MTHI while busy is ignored
        sb.push_back('{"mthi_busy", 32'h0, 32'h0000000C, 1'b0});
        launch("mthi_busy", MD_MULTU, 32'd3, 32'd4);
        tick();
        bus.wdata = 32'hDEADBEEF;
        bus.mthi  = 1'b1;
        tick();
        bus.mthi  = 1'b0;
        check("mthi_busy.hi_held", bus.hi, 32'h55AA55AA);
        wait_idle("mthi_busy");
        tick();

        // start wins over a simultaneous MTHI/MTLO
        bus.wdata = 32'hFFFF0000;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        sb.push_back('{"start_wins", 32'h0, 32'h00000006, 1'b0});
        launch("start_wins", MD_MULTU, 32'd2, 32'd3);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("start_wins.hi_held", bus.hi, 32'h00000000);
        check("start_wins.lo_held", bus.lo, 32'h0000000C);
        wait_idle("start_wins");
        tick();

        // Second start during busy is ignored
        sb.push_back('{"restart_ign", 32'h00000001, 32'hFFFFFFFE, 1'b0});
        launch("restart_ign", MD_MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (4) tick();
        bus.op    = MD_DIVU;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle("restart_ign");
        tick();
        check("restart_ign.no_relaunch", {31'b0, bus.busy}, 32'd0);

        // Asynchronous reset mid-operation aborts it
        launch("abort", MD_MULTU, 32'd3, 32'd4);
        repeat (9) tick();
        #3 rst_n = 1'b0;
        #1;
        check("abort.busy", {31'b0, bus.busy}, 32'd0);
        check("abort.hi",   bus.hi, 32'd0);
        check("abort.lo",   bus.lo, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("abort.no_done", {31'b0, bus.done}, 32'd0);

        run_op("post_reset", MD_MULTU, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0);
        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside alu_32; takes the same ID/EX operands (a = rs, b = rt).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the architectural HI/LO registers.
- Also serves MTHI/MTLO writes and drives HI/LO to the writeback mux for MFHI/MFLO.
- Raises busy so the hazard unit stalls the pipeline.

Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; honoured only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  WIDTH  rs operand (multiplicand/dividend); sampled with start
- b  in  WIDTH  rt operand (multiplier/divisor); sampled with start
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, HI/LO just updated
- div_by_zero  out  1  one-cycle pulse, coincident with done, for a DIV/DIVU with b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; count and work registers cleared. Reset mid-operation aborts it: no done pulse, HI/LO become 0.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op, |a|, |b| (magnitudes for signed ops), result signs, a_orig; count=0; go to CALC. busy=1 from E0.
- CALC: one iteration per edge, E1..E32; count increments; at count=WIDTH-1 go to FIX.
  - Multiply: shift-add over a 2*WIDTH product register.
  - Divide: restoring, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- FIX (edge E33):
  - Apply sign correction. Signed multiply: negate the 64-bit product if sign(a)^sign(b). Signed divide: quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Write HI (product[63:32] / remainder) and LO (product[31:0] / quotient).
  - done=1 for the cycle after E33; busy=0 after E33. Total: start to HI/LO valid = 33 edges.
- Divide by zero: iterations still run for the fixed latency. Result is forced to lo=FFFFFFFF, hi=a_orig, with no sign fix; div_by_zero pulses with done.
- DIV 0x80000000 / FFFFFFFF: lo=80000000 (wraps), hi=0, no flag.
- Operand magnitudes: |0x80000000| is handled as unsigned 0x80000000, so no overflow occurs in the magnitude path.
- start while busy=1: ignored; the operation in flight is unaffected.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; written at the next edge.
  - Both asserted: both written with wdata.
  - Asserted while busy, or in the same cycle as an accepted start: ignored; start wins.
- hi/lo change only on reset, FIX, or an accepted mthi/mtlo.
- done and div_by_zero are registered, never combinational.

Decomposition:
- Shared package holds:
  - op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
  - state encoding: IDLE, CALC, FIX
  - MD_LATENCY=33, used by the hazard unit and the bench
- One sub-module, muldiv_step: combinational single iteration (shift-add or restore-subtract) selected by a mul/div bit. The FSM, counter, sign logic and HI/LO stay in muldiv_unit.

Test Plan:
- MULTU a=FFFFFFFF, b=FFFFFFFF -> busy high 33 cycles; done pulses once; hi=FFFFFFFE, lo=00000001.
- MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=5, b=0 -> lo=FFFFFFFF, hi=5; div_by_zero=1 in the same cycle as done.
- MTHI wdata=12345678 then MTLO wdata=9ABCDEF0 in IDLE -> hi/lo update next edge. MTHI during busy -> hi unchanged. Second start at cycle 5 of a MULTU -> ignored; first result intact.
- Start MULTU 3x4, drop rst_n asynchronously (between edges) at cycle 10 -> busy, hi, lo go to 0 immediately; no done. After release, MULTU 3x4 -> lo=0000000C, hi=0.
